// File: rtl/axi4lite_ram_slave.sv
// axi4lite_ram_slave
// AXI4-Lite slave in front of a word-addressed, byte-writable 32-bit RAM.
// Independent write (AW/W -> B) and read (AR -> R) engines. Every output is
// driven straight from a register. Accesses outside the RAM window are
// answered with SLVERR and have no side effects.
module axi4lite_ram_slave #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // write address channel
  input  logic [31:0] S_AWADDR,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  // write data channel
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  // write response channel
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  // read address channel
  input  logic [31:0] S_ARADDR,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  // read data channel
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RVALID,
  input  logic        S_RREADY
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic WR_IDLE = 1'b0;
  localparam logic WR_RESP = 1'b1;
  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // An address hits the RAM only when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr[31:ADDR_W+2] == '0);
  endfunction

  // Word index; the byte offset addr[1:0] plays no part in the access.
  function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
    return addr[ADDR_W+1:2];
  endfunction

  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Storage. It has no reset, and this model does not initialise it at time 0.
  // Zero fill (INIT_ZERO) is left to the simulation environment, so the
  // parameter is carried only for interface compatibility.
  logic [31:0] mem [0:DEPTH-1];

  logic unused_init_zero;
  assign unused_init_zero = INIT_ZERO;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  logic        wr_state;
  logic        aw_ready;
  logic        w_ready;
  logic        aw_held;
  logic        w_held;
  logic        bvalid;
  logic [1:0]  bresp;

  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        aw_got;
  logic        w_got;
  logic        wr_commit;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_in_range;
  logic [ADDR_W-1:0] wr_idx;

  assign aw_hs = S_AWVALID && aw_ready;
  assign w_hs  = S_WVALID  && w_ready;

  // Merge this cycle's handshakes with anything already held and decide whether
  // the write can be committed at the coming edge.
  always_comb begin
    aw_got      = aw_held || aw_hs;
    w_got       = w_held  || w_hs;
    wr_commit   = (wr_state == WR_IDLE) && aw_got && w_got;
    wr_addr     = aw_hs ? S_AWADDR : aw_addr_q;
    wr_data     = w_hs  ? S_WDATA  : w_data_q;
    wr_strb     = w_hs  ? S_WSTRB  : w_strb_q;
    wr_in_range = addr_in_range(wr_addr);
    wr_idx      = word_index(wr_addr);
  end

  // Capture the payload of whichever write channel handshakes first.
  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_addr_q <= S_AWADDR;
    if (w_hs) begin
      w_data_q <= S_WDATA;
      w_strb_q <= S_WSTRB;
    end
  end

  // Write control: collect AW and W in any order, commit, then hold B until taken.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (wr_commit) begin
        wr_state <= WR_RESP;
        aw_ready <= 1'b0;
        w_ready  <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid   <= 1'b1;
        bresp    <= resp_for(wr_in_range);
      end else begin
        aw_held  <= aw_got;
        w_held   <= w_got;
        aw_ready <= !aw_got;
        w_ready  <= !w_got;
      end
    end else begin
      if (bvalid && S_BREADY) begin
        wr_state <= WR_IDLE;
        bvalid   <= 1'b0;
        aw_ready <= 1'b1;
        w_ready  <= 1'b1;
      end
    end
  end

  // RAM write port: only strobed bytes of an in-range commit change.
  always_ff @(posedge ACLK) begin
    if (wr_commit && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  logic        rd_state;
  logic        ar_ready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  logic        ar_hs;
  logic        rd_in_range;
  logic [31:0] rd_word;

  assign ar_hs = S_ARVALID && ar_ready;

  // Decode the read address and look up the word it selects.
  always_comb begin
    rd_in_range = addr_in_range(S_ARADDR);
    rd_word     = mem[word_index(S_ARADDR)];
  end

  // Read control: sample RAM on AR (old data if written at the same edge),
  // then hold R stable until taken.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs) begin
        rd_state <= RD_DATA;
        ar_ready <= 1'b0;
        rvalid   <= 1'b1;
        rresp    <= resp_for(rd_in_range);
        rdata    <= rd_in_range ? rd_word : 32'h0;
      end else begin
        ar_ready <= 1'b1;
      end
    end else begin
      if (rvalid && S_RREADY) begin
        rd_state <= RD_IDLE;
        rvalid   <= 1'b0;
        ar_ready <= 1'b1;
      end
    end
  end

  assign S_AWREADY = aw_ready;
  assign S_WREADY  = w_ready;
  assign S_BVALID  = bvalid;
  assign S_BRESP   = bresp;
  assign S_ARREADY = ar_ready;
  assign S_RVALID  = rvalid;
  assign S_RRESP   = rresp;
  assign S_RDATA   = rdata;

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Directed bench for axi4lite_ram_slave: a table of write-then-read vectors
// followed by hand-written sequences for ordering, backpressure, same-edge
// read/write and mid-transaction reset.
module tb_axi4lite_ram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [31:0] S_ARADDR = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  axi4lite_ram_slave #(.ADDR_W(10), .INIT_ZERO(1'b0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] araddr;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // AW and W presented together; B taken as soon as it appears.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_pend, w_pend, aw_fire, w_fire;
    aw_pend = 1'b1; w_pend = 1'b1;
    S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    for (int i = 0; i < 20 && (aw_pend || w_pend); i++) begin
      aw_fire = S_AWVALID && S_AWREADY;
      w_fire  = S_WVALID && S_WREADY;
      step();
      if (aw_fire) begin aw_pend = 1'b0; S_AWVALID = 1'b0; end
      if (w_fire)  begin w_pend  = 1'b0; S_WVALID  = 1'b0; end
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    if (aw_pend || w_pend) begin
      check({tag, "_aw_w_timeout"}, 32'd0, 32'd1);
      resp = 2'bxx;
      return;
    end
    check({tag, "_bvalid_latency"}, {31'd0, S_BVALID}, 32'd1);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    step();
    S_BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, {31'd0, S_BVALID}, 32'd0);
    check({tag, "_awready_back"}, {30'd0, S_AWREADY, S_WREADY}, 32'd3);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    bit fired;
    fired = 1'b0;
    S_ARADDR = addr; S_ARVALID = 1'b1;
    for (int i = 0; i < 20 && !fired; i++) begin
      fired = S_ARREADY;
      step();
    end
    S_ARVALID = 1'b0;
    if (!fired) begin
      check({tag, "_ar_timeout"}, 32'd0, 32'd1);
      data = 'x; resp = 'x;
      return;
    end
    check({tag, "_rvalid_latency"}, {31'd0, S_RVALID}, 32'd1);
    data = S_RDATA; resp = S_RRESP;
    S_RREADY = 1'b1;
    step();
    S_RREADY = 1'b0;
    check({tag, "_rvalid_drop"}, {31'd0, S_RVALID}, 32'd0);
    check({tag, "_arready_back"}, {31'd0, S_ARREADY}, 32'd1);
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0010, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0000_0000, 2'b00, 32'h1234_5678, 2'b00};
    vecs[2] = '{32'h0000_2000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 2'b10, 32'h1234_5678, 2'b00};
    vecs[3] = '{32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 32'h0000_0014, 2'b00, 32'hFFFF_FFFF, 2'b00};
    vecs[4] = '{32'h0000_0014, 32'h0000_0000, 4'h5, 32'h0000_0016, 2'b00, 32'hFF00_FF00, 2'b00};
    vecs[5] = '{32'h0000_0014, 32'h5555_5555, 4'h0, 32'h0000_0014, 2'b00, 32'hFF00_FF00, 2'b00};
    vecs[6] = '{32'h0000_0FFC, 32'h0A0B_0C0D, 4'hF, 32'h0000_0FFF, 2'b00, 32'h0A0B_0C0D, 2'b00};
    vecs[7] = '{32'h0000_1000, 32'h0000_0001, 4'hF, 32'h0000_1000, 2'b10, 32'h0000_0000, 2'b10};
    vecs[8] = '{32'h8000_0000, 32'h0000_0002, 4'hF, 32'h0000_2004, 2'b10, 32'h0000_0000, 2'b10};

    // reset state
    repeat (3) step();
    check("rst_awready", {31'd0, S_AWREADY}, 32'd0);
    check("rst_wready",  {31'd0, S_WREADY},  32'd0);
    check("rst_arready", {31'd0, S_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, S_BVALID},  32'd0);
    check("rst_bresp",   {30'd0, S_BRESP},   32'd0);
    check("rst_rvalid",  {31'd0, S_RVALID},  32'd0);
    check("rst_rresp",   {30'd0, S_RRESP},   32'd0);
    check("rst_rdata",   S_RDATA,            32'd0);
    ARESETn = 1'b1;
    check("rel_readies_low", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd0);
    step();
    check("rel_readies_up", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);

    // table of write-then-read vectors
    for (int i = 0; i < 9; i++) begin
      do_write($sformatf("v%0d_wr", i), vecs[i].awaddr, vecs[i].wdata, vecs[i].wstrb, br);
      check($sformatf("v%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].bresp});
      do_read($sformatf("v%0d_rd", i), vecs[i].araddr, rd, rr);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].rresp});
    end

    // W three cycles ahead of AW
    S_WDATA = 32'h0000_00AA; S_WSTRB = 4'b0001; S_WVALID = 1'b1;
    check("wfirst_wready", {31'd0, S_WREADY}, 32'd1);
    step();
    S_WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wfirst_wready_low%0d", k), {31'd0, S_WREADY}, 32'd0);
      check($sformatf("wfirst_awready%0d", k), {31'd0, S_AWREADY}, 32'd1);
      check($sformatf("wfirst_nobvalid%0d", k), {31'd0, S_BVALID}, 32'd0);
      step();
    end
    S_AWADDR = 32'h0000_0010; S_AWVALID = 1'b1;
    step();
    S_AWVALID = 1'b0;
    check("wfirst_bvalid", {31'd0, S_BVALID}, 32'd1);
    check("wfirst_bresp", {30'd0, S_BRESP}, 32'd0);
    check("wfirst_wready_resp", {31'd0, S_WREADY}, 32'd0);
    S_BREADY = 1'b1;
    step();
    S_BREADY = 1'b0;
    do_read("wfirst_rd", 32'h0000_0010, rd, rr);
    check("wfirst_rdata", rd, 32'hDEAD_BEAA);

    // backpressure on B and R for five cycles
    S_AWADDR = 32'h0000_0024; S_WDATA = 32'h7777_7777; S_WSTRB = 4'hF;
    S_ARADDR = 32'h0000_0010;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    check("bp_readies", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
    step();
    S_AWADDR = 32'h0000_0030; S_WDATA = 32'h9999_9999; S_ARADDR = 32'h0000_0024;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_bvalid%0d", k), {31'd0, S_BVALID}, 32'd1);
      check($sformatf("bp_bresp%0d", k), {30'd0, S_BRESP}, 32'd0);
      check($sformatf("bp_rvalid%0d", k), {31'd0, S_RVALID}, 32'd1);
      check($sformatf("bp_rdata%0d", k), S_RDATA, 32'hDEAD_BEAA);
      check($sformatf("bp_rresp%0d", k), {30'd0, S_RRESP}, 32'd0);
      check($sformatf("bp_readies%0d", k), {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd0);
      step();
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    step();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    check("bp_release", {30'd0, S_BVALID, S_RVALID}, 32'd0);
    check("bp_readies_back", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
    do_read("bp_rd", 32'h0000_0024, rd, rr);
    check("bp_rdata_after", rd, 32'h7777_7777);

    // same-edge write and read of one word: read returns old contents
    do_write("rbw_pre", 32'h0000_0020, 32'h0000_0000, 4'hF, br);
    S_AWADDR = 32'h0000_0020; S_WDATA = 32'h1111_1111; S_WSTRB = 4'hF;
    S_ARADDR = 32'h0000_0020;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    step();
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    check("rbw_valids", {30'd0, S_BVALID, S_RVALID}, 32'd3);
    check("rbw_old_data", S_RDATA, 32'h0000_0000);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    step();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    do_read("rbw_rd", 32'h0000_0020, rd, rr);
    check("rbw_new_data", rd, 32'h1111_1111);

    // reset while B and R are both pending
    S_AWADDR = 32'h0000_0028; S_WDATA = 32'h5A5A_5A5A; S_WSTRB = 4'hF;
    S_ARADDR = 32'h0000_0010;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    step();
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    check("mrst_pending", {30'd0, S_BVALID, S_RVALID}, 32'd3);
    ARESETn = 1'b0;
    #1;
    check("mrst_async_drop", {30'd0, S_BVALID, S_RVALID}, 32'd0);
    check("mrst_async_readies", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd0);
    check("mrst_async_rdata", S_RDATA, 32'd0);
    step(); step();
    ARESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mrst_no_resp%0d", k), {30'd0, S_BVALID, S_RVALID}, 32'd0);
    end
    check("mrst_readies", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
    do_read("mrst_rd28", 32'h0000_0028, rd, rr);
    check("mrst_rdata28", rd, 32'h5A5A_5A5A);
    do_read("mrst_rd10", 32'h0000_0010, rd, rr);
    check("mrst_rdata10", rd, 32'hDEAD_BEAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
